nios2_debug_slave_cmd_sync: RTL

//  Parametrised system-clock side of the Nios II JTAG debug slave.
//  - Brings the virtual-JTAG update strobes (UIR/UDR) from the TCK domain into clk.
//  - Captures the scanned data register and instruction.
//  - Decodes the instruction into one-hot per-channel action / no-action pulses.
//  - Presents each command to the OCI logic through a valid/ready handshake with

---
 rtl/nios2_debug_slave_cmd_sync.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nios2_debug_slave_cmd_sync.sv
// nios2_debug_slave_cmd_sync
// System-clock side of the Nios II JTAG debug slave: synchronises the
// virtual-JTAG UIR/UDR strobes, captures IR and DR, decodes per-channel
// action / no-action pulses and hands each command to the OCI logic through
// a valid/ready handshake with sticky overflow detection.
// Optional feature: define DEBUG_SLAVE_PARITY_EN to add the sr_par input and
// the parity_err output (even parity over {sr, sr_par} checked on every UDR).
module nios2_debug_slave_cmd_sync #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_BIT     = 34
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_W-1:0]      sr,
    input  logic [IR_W-1:0]        ir_in,
    input  logic                   vs_uir,
    input  logic                   vs_udr,
    input  logic                   cmd_ready,
    input  logic                   clr_overflow,
`ifdef DEBUG_SLAVE_PARITY_EN
    input  logic                   sr_par,
    output logic                   parity_err,
`endif
    output logic [DATA_W-1:0]      jdo,
    output logic [IR_W-1:0]        cmd_ir,
    output logic                   cmd_valid,
    output logic [(2**IR_W)-1:0]   take_action,
    output logic [(2**IR_W)-1:0]   take_no_action,
    output logic                   ir_update,
    output logic                   overflow
);

    localparam int unsigned NCH = 2**IR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Synchroniser chains plus one delay flop each for edge detection
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic                   uir_dly_q;
    logic                   udr_dly_q;
    logic                   uir_p;
    logic                   udr_p;

    // Captured instruction and command registers
    logic [IR_W-1:0]        ir_q;
    logic                   ir_update_q;
    state_t                 state_q;
    logic [DATA_W-1:0]      jdo_q;
    logic [IR_W-1:0]        cmd_ir_q;
    logic                   cmd_valid_q;
    logic [NCH-1:0]         take_action_q;
    logic [NCH-1:0]         take_no_action_q;
    logic                   overflow_q;

    // Decode and qualification
    logic [NCH-1:0]         ch_onehot;
    logic                   par_ok;
    logic                   udr_ok;

    // Bring both TCK-domain strobes into clk through SYNC_STAGES flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        end
    end

    // Delay the last synchroniser stage so a held level yields a single pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_dly_q <= 1'b0;
            udr_dly_q <= 1'b0;
        end else begin
            uir_dly_q <= uir_sync_q[SYNC_STAGES-1];
            udr_dly_q <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign uir_p = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
    assign udr_p = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;

    // Latch the virtual IR; a simultaneous UDR still sees the previous value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q        <= '0;
            ir_update_q <= 1'b0;
        end else begin
            ir_update_q <= uir_p;
            if (uir_p) begin
                ir_q <= ir_in;
            end
        end
    end

    // One-hot channel select from the currently latched instruction
    always_comb begin
        ch_onehot       = '0;
        ch_onehot[ir_q] = 1'b1;
    end

`ifdef DEBUG_SLAVE_PARITY_EN
    logic parity_err_q;

    assign par_ok = ~^{sr, sr_par};

    // Flag a bad-parity UDR on the edge where it would otherwise be captured
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= udr_p & ~par_ok;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign par_ok = 1'b1;
`endif

    // A bad-parity UDR behaves as if no UDR arrived at all
    assign udr_ok = udr_p & par_ok;

    // Command handshake: capture, pulse, hold while pending, flag drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            jdo_q            <= '0;
            cmd_ir_q         <= '0;
            cmd_valid_q      <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            take_action_q    <= '0;
            take_no_action_q <= '0;
            if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (udr_ok) begin
                        jdo_q            <= sr;
                        cmd_ir_q         <= ir_q;
                        take_action_q    <= sr[ACT_BIT] ? ch_onehot : '0;
                        take_no_action_q <= sr[ACT_BIT] ? '0 : ch_onehot;
                        cmd_valid_q      <= 1'b1;
                        state_q          <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (udr_ok && cmd_ready) begin
                        jdo_q            <= sr;
                        cmd_ir_q         <= ir_q;
                        take_action_q    <= sr[ACT_BIT] ? ch_onehot : '0;
                        take_no_action_q <= sr[ACT_BIT] ? '0 : ch_onehot;
                    end else if (udr_ok) begin
                        // set takes priority over a same-cycle clear
                        overflow_q <= 1'b1;
                    end else if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign jdo            = jdo_q;
    assign cmd_ir         = cmd_ir_q;
    assign cmd_valid      = cmd_valid_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign ir_update      = ir_update_q;
    assign overflow       = overflow_q;

endmodule
